// File: rtl/alloc_pkg.sv
// Shared allocator types: FSM state encoding, block handle, and handle range check.
package alloc_pkg;

    localparam int ALLOC_MAU        = 32;
    localparam int ALLOC_NUM_BLOCKS = 32;
    localparam int ALLOC_NBW        = $clog2(ALLOC_NUM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        READ  = 2'd2,
        FREE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ALLOC_NBW-1:0] addr;
        logic [ALLOC_NBW-1:0] size;
    } handle_t;

    // A handle is usable when it is non-empty and ends at or before the last block.
    // The end is computed one bit wider so addr+size never wraps.
    function automatic logic handle_ok(handle_t h, int num_blocks);
        logic [ALLOC_NBW:0] end_blk;
        end_blk = {1'b0, h.addr} + {1'b0, h.size};
        return (h.size != '0) && (end_blk <= (ALLOC_NBW+1)'(num_blocks));
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer for EBR read data. When empty, incoming data bypasses
// straight to the output so a read shows up the cycle its data returns.
module rd_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic [1:0]   count_o
);

    logic [W-1:0] ent_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    // Store only what cannot leave this cycle; the upstream issue limit keeps cnt_q <= 2.
    assign push        = in_valid_i && !((cnt_q == 2'd0) && out_ready_i);
    assign pop         = (cnt_q != 2'd0) && out_ready_i;
    assign out_valid_o = (cnt_q != 2'd0) || in_valid_i;
    assign out_data_o  = (cnt_q != 2'd0) ? ent_q[rd_q] : (in_valid_i ? in_data_i : '0);
    assign count_o     = cnt_q;

    // Circular storage with separate write/read pointers and an occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                ent_q[wr_q] <= in_data_i;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/buf_reader.sv
// Streams the words of an allocated handle out of the block EBR, then hands the
// blocks back to the allocator as a free request.
module buf_reader
    import alloc_pkg::*;
#(
    parameter int MAU              = ALLOC_MAU,
    parameter int NUM_BLOCKS       = ALLOC_NUM_BLOCKS,
    parameter int NUM_BLOCKS_WIDTH = $clog2(NUM_BLOCKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [NUM_BLOCKS_WIDTH-1:0] i_addr,
    input  logic [NUM_BLOCKS_WIDTH-1:0] i_size,
    output logic                        mem_rd_en,
    output logic [NUM_BLOCKS_WIDTH-1:0] mem_rd_addr,
    input  logic [MAU-1:0]              mem_rd_data,
    output logic [MAU-1:0]              o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last,
    output logic                        o_err,
    output logic                        free_valid,
    input  logic                        free_ready,
    output logic [NUM_BLOCKS_WIDTH-1:0] free_addr,
    output logic [NUM_BLOCKS_WIDTH-1:0] free_size
);

    localparam int NBW = NUM_BLOCKS_WIDTH;
    localparam logic [NBW:0]   ONE_W = (NBW+1)'(1);
    localparam logic [NBW-1:0] ONE_P = NBW'(1);

    state_e         state_q, state_d;
    handle_t        hdl_q, hdl_d;
    logic [NBW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NBW:0]   issued_q, issued_d;
    logic           inflight_q;
    logic           inflight_last_q;
    logic [1:0]     buf_cnt;
    logic [MAU:0]   skid_out;
    logic           bad;
    logic           rd_en;
    logic           rd_last;
    logic           final_fire;

    assign bad = !handle_ok(hdl_q, NUM_BLOCKS);

    // EBR latency is one cycle, so at most one read is ever in flight; the issue
    // limit guarantees the skid buffer can absorb everything already requested.
    assign rd_en = (state_q == READ)
                && (issued_q < {1'b0, hdl_q.size})
                && (({1'b0, inflight_q} + buf_cnt) < 2'd2);
    assign rd_last    = (issued_q == ({1'b0, hdl_q.size} - ONE_W));
    assign final_fire = o_valid && i_ready && o_last;

    rd_skid_buf #(.W(MAU + 1)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   ({inflight_last_q, mem_rd_data}),
        .out_valid_o (o_valid),
        .out_data_o  (skid_out),
        .out_ready_i (i_ready),
        .count_o     (buf_cnt)
    );

    assign o_last      = skid_out[MAU];
    assign o_data      = skid_out[MAU-1:0];
    assign o_ready     = (state_q == IDLE);
    assign o_err       = (state_q == CHECK) && bad;
    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_ptr_q;
    assign free_valid  = (state_q == FREE);
    assign free_addr   = free_valid ? hdl_q.addr : '0;
    assign free_size   = free_valid ? hdl_q.size : '0;

    // Handle lifecycle: accept, range-check, stream, free.
    always_comb begin
        state_d  = state_q;
        hdl_d    = hdl_q;
        rd_ptr_d = rd_ptr_q;
        issued_d = issued_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    hdl_d.addr = i_addr;
                    hdl_d.size = i_size;
                    rd_ptr_d   = i_addr;
                    issued_d   = '0;
                    state_d    = CHECK;
                end
            end
            CHECK: state_d = bad ? IDLE : READ;
            READ: begin
                if (rd_en) begin
                    rd_ptr_d = rd_ptr_q + ONE_P;
                    issued_d = issued_q + ONE_W;
                end
                if (final_fire) state_d = FREE;
            end
            FREE: begin
                if (free_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; a read issued this cycle returns data (and its last tag) next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            hdl_q           <= '0;
            rd_ptr_q        <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hdl_q           <= hdl_d;
            rd_ptr_q        <= rd_ptr_d;
            issued_q        <= issued_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
        end
    end

endmodule
